// File: rtl/isa_pkg.sv
// isa_pkg
// Shared types and default constants for the ISA I/O slave.
//   isa_state_e   : bus-cycle FSM states
//   ISA_SA_W      : width of the ISA system address bus
//   ISA_ADDR_W    : default decoded I/O address width
//   ISA_NUM_WIN   : default number of decoded windows
//   ISA_WIN_BASE  : default packed window base addresses (window 0 in LSBs)
//   ISA_WIN_MASK  : default packed window compare masks (same packing)
package isa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD_REQ,
    ST_RD_HOLD,
    ST_WR_WAIT
  } isa_state_e;

  localparam int ISA_SA_W    = 20;
  localparam int ISA_ADDR_W  = 16;
  localparam int ISA_NUM_WIN = 4;

  localparam logic [ISA_NUM_WIN*ISA_ADDR_W-1:0] ISA_WIN_BASE =
    {16'h0388, 16'h0330, 16'h0220, 16'h0201};
  localparam logic [ISA_NUM_WIN*ISA_ADDR_W-1:0] ISA_WIN_MASK =
    {16'hFFFC, 16'hFFFF, 16'hFFF0, 16'hFFFF};

endpackage

// File: rtl/isa_io_slave_if.sv
// isa_io_slave_if
// Bundles the ISA pin-side signals and the internal function-bus signals.
//   ISA side : isa_sa, isa_bale, isa_aen, isa_ior_n, isa_iow_n, isa_sd_in (to slave)
//              isa_sd_out, isa_sd_oe (from slave)
//   Bus side : win_sel, bus_addr, bus_wr, bus_rd, bus_wdata, proto_err (from slave)
//              bus_rdata (to slave)
// Modports: slave (the I/O slave), master (ISA host plus decoded functions).
interface isa_io_slave_if
  import isa_pkg::*;
#(
  parameter int NUM_WIN = ISA_NUM_WIN,
  parameter int ADDR_W  = ISA_ADDR_W
);

  logic [ISA_SA_W-1:0] isa_sa;
  logic                isa_bale;
  logic                isa_aen;
  logic                isa_ior_n;
  logic                isa_iow_n;
  logic [7:0]          isa_sd_in;
  logic [7:0]          isa_sd_out;
  logic                isa_sd_oe;

  logic [NUM_WIN-1:0]  win_sel;
  logic [ADDR_W-1:0]   bus_addr;
  logic                bus_wr;
  logic                bus_rd;
  logic [7:0]          bus_wdata;
  logic [7:0]          bus_rdata;
  logic                proto_err;

  modport slave (
    input  isa_sa, isa_bale, isa_aen, isa_ior_n, isa_iow_n, isa_sd_in, bus_rdata,
    output isa_sd_out, isa_sd_oe, win_sel, bus_addr, bus_wr, bus_rd, bus_wdata,
           proto_err
  );

  modport master (
    output isa_sa, isa_bale, isa_aen, isa_ior_n, isa_iow_n, isa_sd_in, bus_rdata,
    input  isa_sd_out, isa_sd_oe, win_sel, bus_addr, bus_wr, bus_rd, bus_wdata,
           proto_err
  );

endinterface

// File: rtl/isa_sync.sv
// isa_sync
// Single-bit multi-flop synchroniser with a configurable reset value.
//   clk     : sampling clock
//   reset   : synchronous, active-high; loads RST_VAL into every stage
//   d_i     : asynchronous input
//   q_o     : synchronised output, STAGES cycles behind d_i
module isa_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/isa_io_slave.sv
// isa_io_slave
// ISA I/O-space slave: synchronises the ISA strobes, latches the address on
// BALE, decodes it against NUM_WIN base/mask windows and turns IOR/IOW
// strobes into single-cycle bus_rd / bus_wr pulses for the selected function.
//   clk, reset : clock and synchronous active-high reset
//   isa_if     : isa_io_slave_if.slave (ISA pins and function-bus signals)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no address latched since reset
// ST_ADDR    | address latched, waiting for a strobe or a new BALE
// ST_RD_REQ  | bus_rd pulse out; bus_rdata captured at the end of this cycle
// ST_RD_HOLD | driving read register onto SD until IOR goes high
// ST_WR_WAIT | IOW low, sampling SD; bus_wr fires when IOW rises
module isa_io_slave
  import isa_pkg::*;
#(
  parameter int NUM_WIN     = ISA_NUM_WIN,
  parameter int ADDR_W      = ISA_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BASE = ISA_WIN_BASE,
  parameter logic [NUM_WIN*ADDR_W-1:0] WIN_MASK = ISA_WIN_MASK
) (
  input logic           clk,
  input logic           reset,
  isa_io_slave_if.slave isa_if
);

  logic bale_s, ior_s, iow_s, aen_s;

  isa_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_bale (
    .clk(clk), .reset(reset), .d_i(isa_if.isa_bale), .q_o(bale_s));
  isa_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ior (
    .clk(clk), .reset(reset), .d_i(isa_if.isa_ior_n), .q_o(ior_s));
  isa_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_iow (
    .clk(clk), .reset(reset), .d_i(isa_if.isa_iow_n), .q_o(iow_s));
  isa_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_aen (
    .clk(clk), .reset(reset), .d_i(isa_if.isa_aen), .q_o(aen_s));

  isa_state_e          state_q, state_d;
  logic [ISA_SA_W-1:0] sa_q;
  logic [7:0]          sd_q;
  logic                bale_prev_q, ior_prev_q, iow_prev_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_WIN-1:0]  win_sel_q, win_sel_d;
  logic                bus_rd_q, bus_rd_d;
  logic                bus_wr_q, bus_wr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          wr_hold_q, wr_hold_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                oe_q, oe_d;
  logic                perr_q, perr_d;

  logic bale_fall, ior_fall, iow_fall, hit;

  // Only the decoded part of SA is used; upper bits are registered but ignored.
  if (ADDR_W < ISA_SA_W) begin : g_sa_unused
    logic unused_sa_hi;
    assign unused_sa_hi = ^sa_q[ISA_SA_W-1:ADDR_W];
  end

  // Scanning from the top down leaves the lowest matching window selected.
  function automatic logic [NUM_WIN-1:0] first_hit(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] m;
    first_hit = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      m = WIN_MASK[i*ADDR_W +: ADDR_W];
      if ((a & m) == (WIN_BASE[i*ADDR_W +: ADDR_W] & m)) begin
        first_hit    = '0;
        first_hit[i] = 1'b1;
      end
    end
  endfunction

  assign bale_fall = bale_prev_q & ~bale_s;
  assign ior_fall  = ior_prev_q & ~ior_s;
  assign iow_fall  = iow_prev_q & ~iow_s;
  assign hit       = |win_sel_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bus_rd_d  = 1'b0;
    bus_wr_d  = 1'b0;
    wdata_d   = wdata_q;
    wr_hold_d = wr_hold_q;
    rd_data_d = rd_data_q;
    perr_d    = perr_q;

    if (!iow_s && (state_q == ST_ADDR || state_q == ST_WR_WAIT)) begin
      wr_hold_d = sd_q;
    end

    if (state_q != ST_IDLE && hit && !ior_s && !iow_s) begin
      perr_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bale_fall) begin
          addr_d  = sa_q[ADDR_W-1:0];
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bale_fall) begin
          addr_d = sa_q[ADDR_W-1:0];
        end else if (hit && ior_s != iow_s) begin
          // Exactly one strobe low; the both-low case only flags proto_err.
          if (ior_fall) begin
            bus_rd_d = 1'b1;
            state_d  = ST_RD_REQ;
          end else if (iow_fall) begin
            state_d = ST_WR_WAIT;
          end
        end
      end
      ST_RD_REQ: begin
        rd_data_d = isa_if.bus_rdata;
        state_d   = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (ior_s) begin
          state_d = ST_ADDR;
        end
      end
      ST_WR_WAIT: begin
        if (iow_s) begin
          bus_wr_d = 1'b1;
          wdata_d  = wr_hold_q;
          state_d  = ST_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    win_sel_d = (state_d == ST_IDLE) ? '0 : (first_hit(addr_d) & {NUM_WIN{~aen_s}});
    oe_d      = (state_d == ST_RD_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sa_q        <= '0;
      sd_q        <= '0;
      bale_prev_q <= 1'b0;
      ior_prev_q  <= 1'b1;
      iow_prev_q  <= 1'b1;
      addr_q      <= '0;
      win_sel_q   <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      wdata_q     <= '0;
      wr_hold_q   <= '0;
      rd_data_q   <= '0;
      oe_q        <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= isa_if.isa_sa;
      sd_q        <= isa_if.isa_sd_in;
      bale_prev_q <= bale_s;
      ior_prev_q  <= ior_s;
      iow_prev_q  <= iow_s;
      addr_q      <= addr_d;
      win_sel_q   <= win_sel_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      wdata_q     <= wdata_d;
      wr_hold_q   <= wr_hold_d;
      rd_data_q   <= rd_data_d;
      oe_q        <= oe_d;
      perr_q      <= perr_d;
    end
  end

  assign isa_if.isa_sd_out = rd_data_q;
  assign isa_if.isa_sd_oe  = oe_q;
  assign isa_if.win_sel    = win_sel_q;
  assign isa_if.bus_addr   = addr_q;
  assign isa_if.bus_wr     = bus_wr_q;
  assign isa_if.bus_rd     = bus_rd_q;
  assign isa_if.bus_wdata  = wdata_q;
  assign isa_if.proto_err  = perr_q;

endmodule

// File: tb/tb_isa_io_slave.sv
// tb_isa_io_slave
// Self-checking bench for isa_io_slave: directed scenarios plus randomized
// ISA read/write cycles compared against a cycle-count reference model.
module tb_isa_io_slave;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  isa_io_slave_if #(.NUM_WIN(4), .ADDR_W(16)) bus_if ();

  isa_io_slave dut (
    .clk    (clk),
    .reset  (reset),
    .isa_if (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] win_base [4] = '{16'h0201, 16'h0220, 16'h0330, 16'h0388};
  logic [15:0] win_mask [4] = '{16'hFFFF, 16'hFFF0, 16'hFFFF, 16'hFFFC};

  // Reference decode: lowest-index window whose masked compare matches.
  function automatic logic [3:0] exp_win(input logic [15:0] a, input logic aen);
    if (aen) return 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if ((a & win_mask[i]) == (win_base[i] & win_mask[i])) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  // Monitor: running totals of bus activity seen away from the clock edge.
  int         rd_total = 0, wr_total = 0, oe_total = 0, sdbad_total = 0, both_total = 0;
  int         last_rd_cyc = -100, oe_rise_cyc = -100;
  logic [7:0] last_wdata = 8'h00;
  logic [15:0] last_waddr = 16'h0000;
  logic [7:0] exp_rdata = 8'h00;
  logic       oe_prev = 1'b0;

  always @(negedge clk) begin
    if (bus_if.bus_rd === 1'b1) begin
      rd_total++;
      last_rd_cyc = cyc;
    end
    if (bus_if.bus_wr === 1'b1) begin
      wr_total++;
      last_wdata = bus_if.bus_wdata;
      last_waddr = bus_if.bus_addr;
    end
    if (bus_if.bus_rd === 1'b1 && bus_if.bus_wr === 1'b1) both_total++;
    if (bus_if.isa_sd_oe === 1'b1) begin
      oe_total++;
      if (!oe_prev) oe_rise_cyc = cyc;
      if (bus_if.isa_sd_out !== exp_rdata) sdbad_total++;
    end
    oe_prev = (bus_if.isa_sd_oe === 1'b1);
  end

  typedef struct {
    int          d_rd;
    int          d_wr;
    int          d_oe;
    int          d_sdbad;
    int          lat_rd;
    int          lat_oe;
    logic [3:0]  win;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [15:0] waddr;
  } txn_res_t;

  task automatic do_latch(input logic [15:0] a, input logic aen);
    @(negedge clk);
    bus_if.isa_sa   = {4'($urandom_range(0, 15)), a};
    bus_if.isa_aen  = aen;
    bus_if.isa_bale = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.isa_bale = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // kind: 0 = read, 1 = write, 2 = both strobes together
  task automatic drive_txn(input int kind, input logic [15:0] a, input logic aen,
                           input logic [7:0] d, input int hold, output txn_res_t r);
    int rd0, wr0, oe0, sb0, fall;
    do_latch(a, aen);
    r.win  = bus_if.win_sel;
    r.addr = bus_if.bus_addr;
    rd0 = rd_total; wr0 = wr_total; oe0 = oe_total; sb0 = sdbad_total;
    exp_rdata        = d;
    bus_if.bus_rdata = d;
    bus_if.isa_sd_in = d;
    @(negedge clk);
    fall = cyc;
    if (kind != 1) bus_if.isa_ior_n = 1'b0;
    if (kind != 0) bus_if.isa_iow_n = 1'b0;
    repeat (hold) @(negedge clk);
    bus_if.isa_ior_n = 1'b1;
    bus_if.isa_iow_n = 1'b1;
    repeat (6) @(negedge clk);
    r.d_rd    = rd_total - rd0;
    r.d_wr    = wr_total - wr0;
    r.d_oe    = oe_total - oe0;
    r.d_sdbad = sdbad_total - sb0;
    r.lat_rd  = last_rd_cyc - fall;
    r.lat_oe  = oe_rise_cyc - fall;
    r.wdata   = last_wdata;
    r.waddr   = last_waddr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus_if.win_sel, bus_if.bus_addr, bus_if.bus_wr, bus_if.bus_rd, bus_if.bus_wdata,
         bus_if.isa_sd_out, bus_if.isa_sd_oe, bus_if.proto_err} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got win=%b addr=%h wr=%b rd=%b wd=%h sd=%h oe=%b perr=%b, need all 0",
               bus_if.win_sel, bus_if.bus_addr, bus_if.bus_wr, bus_if.bus_rd, bus_if.bus_wdata,
               bus_if.isa_sd_out, bus_if.isa_sd_oe, bus_if.proto_err);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus_if.win_sel !== 4'b0 || bus_if.isa_sd_oe !== 1'b0 || rd_total + wr_total != 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: win=%b oe=%b pulses=%0d, need 0/0/0",
               bus_if.win_sel, bus_if.isa_sd_oe, rd_total + wr_total);
    end
  endtask

  task automatic test_write_basic();
    txn_res_t r;
    drive_txn(1, 16'h0389, 1'b0, 8'h5A, 8, r);
    n_checks++;
    if (r.win !== 4'b1000) begin
      n_fail++; $display("FAIL wr_win_sel: got %b need 1000", r.win);
    end
    n_checks++;
    if (r.d_wr != 1 || r.d_rd != 0) begin
      n_fail++; $display("FAIL wr_pulses: got wr=%0d rd=%0d need 1/0", r.d_wr, r.d_rd);
    end
    n_checks++;
    if (r.wdata !== 8'h5A || r.waddr !== 16'h0389) begin
      n_fail++; $display("FAIL wr_data_addr: got %h@%h need 5a@0389", r.wdata, r.waddr);
    end
  endtask

  task automatic test_read_basic();
    txn_res_t r;
    drive_txn(0, 16'h0224, 1'b0, 8'hAA, 6, r);
    n_checks++;
    if (r.win !== 4'b0010 || r.addr !== 16'h0224) begin
      n_fail++; $display("FAIL rd_decode: got win=%b addr=%h need 0010/0224", r.win, r.addr);
    end
    n_checks++;
    if (r.d_rd != 1 || r.d_wr != 0) begin
      n_fail++; $display("FAIL rd_pulses: got rd=%0d wr=%0d need 1/0", r.d_rd, r.d_wr);
    end
    n_checks++;
    if (r.lat_rd != SYNC + 1 || r.lat_oe != SYNC + 2) begin
      n_fail++; $display("FAIL rd_latency: got rd=%0d oe=%0d need %0d/%0d",
                         r.lat_rd, r.lat_oe, SYNC + 1, SYNC + 2);
    end
    n_checks++;
    if (r.d_oe != 5 || r.d_sdbad != 0) begin
      n_fail++; $display("FAIL rd_oe_data: got oe_cycles=%0d bad_sd=%0d need 5/0", r.d_oe, r.d_sdbad);
    end
  endtask

  task automatic test_aen();
    txn_res_t r, r2;
    drive_txn(0, 16'h0201, 1'b1, 8'h33, 5, r);
    drive_txn(1, 16'h0201, 1'b1, 8'h44, 5, r2);
    n_checks++;
    if (r.win !== 4'b0 || r.d_rd + r.d_wr + r2.d_rd + r2.d_wr != 0 || r.d_oe + r2.d_oe != 0) begin
      n_fail++; $display("FAIL aen_ignored: win=%b pulses=%0d oe=%0d need 0/0/0", r.win,
                         r.d_rd + r.d_wr + r2.d_rd + r2.d_wr, r.d_oe + r2.d_oe);
    end
  endtask

  task automatic test_nohit();
    txn_res_t r;
    drive_txn(0, 16'h0300, 1'b0, 8'h77, 5, r);
    n_checks++;
    if (r.win !== 4'b0 || r.d_rd != 0 || r.d_oe != 0) begin
      n_fail++; $display("FAIL nohit: win=%b rd=%0d oe=%0d need 0/0/0", r.win, r.d_rd, r.d_oe);
    end
  endtask

  task automatic test_bale_ignored();
    int rd0;
    do_latch(16'h0330, 1'b0);
    rd0 = rd_total;
    exp_rdata = 8'hC3; bus_if.bus_rdata = 8'hC3;
    @(negedge clk);
    bus_if.isa_ior_n = 1'b0;
    repeat (6) @(negedge clk);
    bus_if.isa_sa   = 20'h00201;
    bus_if.isa_bale = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.isa_bale = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus_if.bus_addr !== 16'h0330 || bus_if.isa_sd_oe !== 1'b1) begin
      n_fail++; $display("FAIL bale_frozen: addr=%h oe=%b need 0330/1", bus_if.bus_addr, bus_if.isa_sd_oe);
    end
    bus_if.isa_ior_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (rd_total - rd0 != 1 || bus_if.win_sel !== 4'b0100) begin
      n_fail++; $display("FAIL bale_ignored_read: rd=%0d win=%b need 1/0100", rd_total - rd0, bus_if.win_sel);
    end
  endtask

  task automatic test_random();
    txn_res_t r;
    int kind, hold;
    logic [15:0] a;
    logic aen;
    logic [7:0] d;
    logic [3:0] ew;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 1);
      case ($urandom_range(0, 4))
        0:       a = 16'h0201;
        1:       a = 16'h0220 | 16'($urandom_range(0, 15));
        2:       a = 16'h0330;
        3:       a = 16'h0388 | 16'($urandom_range(0, 3));
        default: a = 16'($urandom);
      endcase
      aen  = ($urandom_range(0, 3) == 0);
      d    = 8'($urandom);
      hold = $urandom_range(3, 8);
      ew   = exp_win(a, aen);
      drive_txn(kind, a, aen, d, hold, r);
      n_checks++;
      if (r.win !== ew || r.addr !== a) begin
        n_fail++; $display("FAIL rand_decode[%0d]: win=%b addr=%h need %b/%h", n, r.win, r.addr, ew, a);
      end
      n_checks++;
      if (r.d_rd != ((ew != 0 && kind == 0) ? 1 : 0) || r.d_wr != ((ew != 0 && kind == 1) ? 1 : 0)) begin
        n_fail++; $display("FAIL rand_pulses[%0d]: rd=%0d wr=%0d kind=%0d win=%b", n, r.d_rd, r.d_wr, kind, ew);
      end
      n_checks++;
      if (r.d_oe != ((ew != 0 && kind == 0) ? hold - 1 : 0) || r.d_sdbad != 0) begin
        n_fail++; $display("FAIL rand_oe[%0d]: oe_cycles=%0d bad_sd=%0d need %0d/0", n, r.d_oe, r.d_sdbad,
                           (ew != 0 && kind == 0) ? hold - 1 : 0);
      end
      if (ew != 0 && kind == 1) begin
        n_checks++;
        if (r.wdata !== d || r.waddr !== a) begin
          n_fail++; $display("FAIL rand_wdata[%0d]: got %h@%h need %h@%h", n, r.wdata, r.waddr, d, a);
        end
      end
    end
    n_checks++;
    if (bus_if.proto_err !== 1'b0) begin
      n_fail++; $display("FAIL rand_no_perr: got %b need 0", bus_if.proto_err);
    end
  endtask

  task automatic test_proto();
    txn_res_t r, r2;
    drive_txn(2, 16'h0330, 1'b0, 8'h11, 5, r);
    n_checks++;
    if (bus_if.proto_err !== 1'b1 || r.d_rd + r.d_wr != 0 || r.d_oe != 0) begin
      n_fail++; $display("FAIL proto: perr=%b pulses=%0d oe=%0d need 1/0/0", bus_if.proto_err,
                         r.d_rd + r.d_wr, r.d_oe);
    end
    drive_txn(0, 16'h0201, 1'b0, 8'h22, 4, r2);
    n_checks++;
    if (bus_if.proto_err !== 1'b1 || r2.d_rd != 1) begin
      n_fail++; $display("FAIL proto_sticky: perr=%b rd=%0d need 1/1", bus_if.proto_err, r2.d_rd);
    end
  endtask

  task automatic test_reset_mid();
    int rd0, wr0, waited;
    do_latch(16'h0224, 1'b0);
    exp_rdata = 8'h96; bus_if.bus_rdata = 8'h96;
    @(negedge clk);
    bus_if.isa_ior_n = 1'b0;
    waited = 0;
    while (bus_if.isa_sd_oe !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited >= 20) begin
      n_fail++; $display("FAIL rst_mid_oe_timeout: oe=%b after %0d cycles need 1", bus_if.isa_sd_oe, waited);
    end
    rd0 = rd_total; wr0 = wr_total;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_if.isa_sd_oe !== 1'b0 || bus_if.win_sel !== 4'b0 || bus_if.bus_addr !== 16'h0 ||
        bus_if.proto_err !== 1'b0 || bus_if.isa_sd_out !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_read: oe=%b win=%b addr=%h perr=%b sd=%h need all 0",
                         bus_if.isa_sd_oe, bus_if.win_sel, bus_if.bus_addr, bus_if.proto_err,
                         bus_if.isa_sd_out);
    end
    bus_if.isa_ior_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (rd_total != rd0 || wr_total != wr0) begin
      n_fail++; $display("FAIL rst_mid_read_pulses: rd=%0d wr=%0d need 0/0", rd_total - rd0, wr_total - wr0);
    end

    do_latch(16'h0389, 1'b0);
    bus_if.isa_sd_in = 8'h3C;
    @(negedge clk);
    bus_if.isa_iow_n = 1'b0;
    repeat (5) @(negedge clk);
    wr0 = wr_total;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_if.isa_iow_n = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (wr_total != wr0 || bus_if.bus_wdata !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_write: wr=%0d wdata=%h need 0/00", wr_total - wr0, bus_if.bus_wdata);
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus_if.isa_sa    = '0;
    bus_if.isa_bale  = 1'b0;
    bus_if.isa_aen   = 1'b1;
    bus_if.isa_ior_n = 1'b1;
    bus_if.isa_iow_n = 1'b1;
    bus_if.isa_sd_in = 8'h00;
    bus_if.bus_rdata = 8'h00;

    test_reset();
    test_write_basic();
    test_read_basic();
    test_aen();
    test_nohit();
    test_bale_ignored();
    test_random();
    test_proto();
    test_reset_mid();

    n_checks++;
    if (both_total != 0) begin
      n_fail++; $display("FAIL rd_wr_exclusive: both asserted in %0d cycles need 0", both_total);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/isa_io_slave.md
ISA_IO_SLAVE -- requirements
Module: isa_io_slave

Interface
REQ-001 SHALL have parameter NUM_WIN, default 4; number of decoded I/O windows (1..8).
REQ-002 SHALL have parameter ADDR_W, default 16; decoded I/O address width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2; synchroniser depth on ISA strobes (2..3).
REQ-004 SHALL have parameter WIN_BASE, default {16'h0388,16'h0330,16'h0220,16'h0201}; packed NUM_WIN*ADDR_W base addresses, window 0 in LSBs.
REQ-005 SHALL have parameter WIN_MASK, default {16'hFFFC,16'hFFFF,16'hFFF0,16'hFFFF}; packed compare masks, same packing.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 isa_sa  in  20  ISA system address.
REQ-009 isa_bale  in  1  address latch enable.
REQ-010 isa_aen  in  1  DMA address enable; high = not an I/O-slave cycle.
REQ-011 isa_ior_n, isa_iow_n  in  1 each  I/O read/write strobes, active-low.
REQ-012 isa_sd_in  in  8  ISA data, low byte.
REQ-013 isa_sd_out  out  8  read data to ISA bus.
REQ-014 isa_sd_oe  out  1  drive enable; top drives SD and SD70_DIR from it.
REQ-015 win_sel  out  NUM_WIN  one-hot hit vector for latched address.
REQ-016 bus_addr  out  ADDR_W  latched address.
REQ-017 bus_wr / bus_rd  out  1 each  single-cycle write/read pulses.
REQ-018 bus_wdata  out  8  write data, valid with bus_wr.
REQ-019 bus_rdata  in  8  read data from selected function, valid 1 cycle after bus_rd.
REQ-020 proto_err  out  1  sticky: IOR and IOW both low while a window hit.

Function
REQ-021 isa_bale, isa_ior_n, isa_iow_n, isa_aen SHALL pass SYNC_STAGES flops; isa_sa and isa_sd_in one register.
REQ-022 Address SHALL latch on synchronised BALE falling edge, in IDLE or ADDR only.
REQ-023 Window i SHALL hit when (addr & MASK_i) == (BASE_i & MASK_i) and synchronised AEN low; if several hit, lowest index alone in win_sel.
REQ-024 States: IDLE, ADDR, RD_REQ, RD_HOLD, WR_WAIT.
REQ-025 IDLE -> ADDR on address latch; ADDR -> ADDR on a new latch.
REQ-026 ADDR, any hit, IOR falling, IOW high -> RD_REQ, bus_rd pulsed that cycle.
REQ-027 RD_REQ -> RD_HOLD next cycle, capturing bus_rdata into read register; isa_sd_oe asserts on the RD_REQ -> RD_HOLD edge.
REQ-028 RD_HOLD: isa_sd_out = read register, isa_sd_oe = 1; on synchronised IOR high -> ADDR, isa_sd_oe deasserts same edge.
REQ-029 ADDR, any hit, IOW falling, IOR high -> WR_WAIT; synchronised SD sampled every cycle IOW low.
REQ-030 WR_WAIT, on IOW rising: one-cycle bus_wr with last data sampled while IOW low; -> ADDR.
REQ-031 No hit or AEN high: strobes ignored, no pulses, isa_sd_oe stays 0.
REQ-032 IOR and IOW both falling/low in ADDR with a hit: stay in ADDR, no pulse, set proto_err.
REQ-033 BALE edges outside IDLE/ADDR SHALL be ignored; address frozen until strobe completes.
REQ-034 bus_rd and bus_wr SHALL never assert in the same cycle; at most one pulse per strobe.
REQ-035 Read latency: bus_rd at SYNC_STAGES+1 cycles after IOR falls at pins; isa_sd_oe 1 cycle later.

Reset
REQ-036 reset SHALL force IDLE, win_sel=0, bus_addr=0, bus_wr=0, bus_rd=0, bus_wdata=0, isa_sd_out=0, isa_sd_oe=0, proto_err=0, synchronisers to inactive (strobes high, BALE low, AEN high).
REQ-037 reset mid-cycle (RD_HOLD, WR_WAIT) SHALL drop isa_sd_oe next edge and suppress any pending bus_wr.

Structure
REQ-038 Package isa_pkg SHALL hold state enum, default ISA_ADDR_W=16, default window base/mask constants.
REQ-039 One sub-module, isa_sync (parametrised-depth single-bit synchroniser with reset value), instanced per strobe.

Verification
REQ-040 BALE latches 0x0389, IOW low 8 cycles with SD=0x5A -> win_sel=4'b1000, one bus_wr with bus_wdata=0x5A, bus_addr=0x0389.
REQ-041 Address 0x0224, IOR low, bus_rdata=0xAA -> bus_rd once, isa_sd_oe high until IOR high, isa_sd_out=0xAA.
REQ-042 Address 0x0201 with AEN high, IOR/IOW strobed -> no pulses, isa_sd_oe=0.
REQ-043 Address 0x0300 (no hit), IOR strobe -> win_sel=0, no bus_rd, isa_sd_oe=0.
REQ-044 Address 0x0330, IOR and IOW low together -> proto_err=1, no pulses; stays 1 until reset.
REQ-045 reset asserted in RD_HOLD -> isa_sd_oe=0 next cycle, state IDLE, no bus_wr/bus_rd.
